// File: rtl/axi_lite_arb_pkg.sv
// ============================================================================
//  Module : axi_lite_arb_pkg
//  Brief  : Shared state encodings and AXI response codes for the memory arbiter.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_lite_arb_pkg;

   typedef logic [1:0] rd_state_t;
   localparam rd_state_t R_IDLE  = 2'd0;
   localparam rd_state_t R_ADDR  = 2'd1;
   localparam rd_state_t R_DATA  = 2'd2;

   typedef logic [1:0] wr_state_t;
   localparam wr_state_t W_IDLE  = 2'd0;
   localparam wr_state_t W_ISSUE = 2'd1;
   localparam wr_state_t W_RESP  = 2'd2;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_lite_mem_arbiter_rr_arb2.sv
// ============================================================================
//  Module : rr_arb2
//  Brief  : Two-requester round-robin picker; ptr breaks ties only.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       grant,
   output logic       any
);

   assign any   = |req;
   // A lone requester always wins regardless of the pointer.
   assign grant = (&req) ? ptr : req[1];

endmodule

`default_nettype wire

// File: rtl/axi_lite_mem_arbiter.sv
// ============================================================================
//  Module : axi_lite_mem_arbiter
//  Brief  : 2:1 AXI4-Lite arbiter, independent round-robin read and write paths.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_mem_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int INIT_PRI = 1
) (
   input  logic                CLK,
   input  logic                RST,
   // master 0 (IMEM)
   input  logic                S0_AXI_arvalid,
   input  logic [ADDR_W-1:0]   S0_AXI_araddr,
   input  logic [2:0]          S0_AXI_arprot,
   output logic                S0_AXI_arready,
   output logic [DATA_W-1:0]   S0_AXI_rdata,
   output logic [1:0]          S0_AXI_rresp,
   output logic                S0_AXI_rvalid,
   input  logic                S0_AXI_rready,
   input  logic                S0_AXI_awvalid,
   input  logic [ADDR_W-1:0]   S0_AXI_awaddr,
   input  logic [2:0]          S0_AXI_awprot,
   output logic                S0_AXI_awready,
   input  logic                S0_AXI_wvalid,
   input  logic [DATA_W-1:0]   S0_AXI_wdata,
   input  logic [DATA_W/8-1:0] S0_AXI_wstrb,
   output logic                S0_AXI_wready,
   output logic [1:0]          S0_AXI_bresp,
   output logic                S0_AXI_bvalid,
   input  logic                S0_AXI_bready,
   // master 1 (DMEM)
   input  logic                S1_AXI_arvalid,
   input  logic [ADDR_W-1:0]   S1_AXI_araddr,
   input  logic [2:0]          S1_AXI_arprot,
   output logic                S1_AXI_arready,
   output logic [DATA_W-1:0]   S1_AXI_rdata,
   output logic [1:0]          S1_AXI_rresp,
   output logic                S1_AXI_rvalid,
   input  logic                S1_AXI_rready,
   input  logic                S1_AXI_awvalid,
   input  logic [ADDR_W-1:0]   S1_AXI_awaddr,
   input  logic [2:0]          S1_AXI_awprot,
   output logic                S1_AXI_awready,
   input  logic                S1_AXI_wvalid,
   input  logic [DATA_W-1:0]   S1_AXI_wdata,
   input  logic [DATA_W/8-1:0] S1_AXI_wstrb,
   output logic                S1_AXI_wready,
   output logic [1:0]          S1_AXI_bresp,
   output logic                S1_AXI_bvalid,
   input  logic                S1_AXI_bready,
   // shared slave
   output logic                M_AXI_arvalid,
   output logic [ADDR_W-1:0]   M_AXI_araddr,
   output logic [2:0]          M_AXI_arprot,
   input  logic                M_AXI_arready,
   input  logic [DATA_W-1:0]   M_AXI_rdata,
   input  logic [1:0]          M_AXI_rresp,
   input  logic                M_AXI_rvalid,
   output logic                M_AXI_rready,
   output logic                M_AXI_awvalid,
   output logic [ADDR_W-1:0]   M_AXI_awaddr,
   output logic [2:0]          M_AXI_awprot,
   input  logic                M_AXI_awready,
   output logic                M_AXI_wvalid,
   output logic [DATA_W-1:0]   M_AXI_wdata,
   output logic [DATA_W/8-1:0] M_AXI_wstrb,
   input  logic                M_AXI_wready,
   input  logic [1:0]          M_AXI_bresp,
   input  logic                M_AXI_bvalid,
   output logic                M_AXI_bready,
   output logic                rd_owner,
   output logic                wr_owner
);

   localparam logic PRI0 = 1'(INIT_PRI);

   // ---------------------------------------------------------------- read path
   rd_state_t           rd_state;
   logic                rd_ptr;
   logic [ADDR_W-1:0]   rd_addr;
   logic [2:0]          rd_prot;
   logic                rd_grant;
   logic                rd_any;
   logic                rd_take;
   logic                rd_data_ph;

   rr_arb2 u_rd_arb (
      .req   ({S1_AXI_arvalid, S0_AXI_arvalid}),
      .ptr   (rd_ptr),
      .grant (rd_grant),
      .any   (rd_any)
   );

   assign rd_take        = (rd_state == R_IDLE) && rd_any;
   assign rd_data_ph     = (rd_state == R_DATA);
   assign S0_AXI_arready = rd_take && !rd_grant;
   assign S1_AXI_arready = rd_take &&  rd_grant;

   assign M_AXI_arvalid  = (rd_state == R_ADDR);
   assign M_AXI_araddr   = rd_addr;
   assign M_AXI_arprot   = rd_prot;
   assign M_AXI_rready   = rd_data_ph && (rd_owner ? S1_AXI_rready : S0_AXI_rready);

   assign S0_AXI_rvalid  = rd_data_ph && !rd_owner && M_AXI_rvalid;
   assign S1_AXI_rvalid  = rd_data_ph &&  rd_owner && M_AXI_rvalid;
   assign S0_AXI_rdata   = M_AXI_rdata;
   assign S1_AXI_rdata   = M_AXI_rdata;
   assign S0_AXI_rresp   = M_AXI_rresp;
   assign S1_AXI_rresp   = M_AXI_rresp;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_state <= R_IDLE;
         rd_ptr   <= PRI0;
         rd_owner <= PRI0;
         rd_addr  <= '0;
         rd_prot  <= '0;
      end else begin
         case (rd_state)
            R_IDLE: if (rd_take) begin
               rd_owner <= rd_grant;
               rd_addr  <= rd_grant ? S1_AXI_araddr : S0_AXI_araddr;
               rd_prot  <= rd_grant ? S1_AXI_arprot : S0_AXI_arprot;
               rd_state <= R_ADDR;
            end
            R_ADDR: if (M_AXI_arready) rd_state <= R_DATA;
            R_DATA: if (M_AXI_rvalid && M_AXI_rready) begin
               rd_ptr   <= !rd_owner;
               rd_state <= R_IDLE;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------- write path
   wr_state_t           wr_state;
   logic                wr_ptr;
   logic [ADDR_W-1:0]   wr_addr;
   logic [2:0]          wr_prot;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W/8-1:0] wr_strb;
   logic                aw_pend;
   logic                w_pend;
   logic                aw_next;
   logic                w_next;
   logic                wr_grant;
   logic                wr_any;
   logic                wr_take;
   logic                wr_resp_ph;

   rr_arb2 u_wr_arb (
      .req   ({S1_AXI_awvalid && S1_AXI_wvalid, S0_AXI_awvalid && S0_AXI_wvalid}),
      .ptr   (wr_ptr),
      .grant (wr_grant),
      .any   (wr_any)
   );

   assign wr_take        = (wr_state == W_IDLE) && wr_any;
   assign wr_resp_ph     = (wr_state == W_RESP);
   assign S0_AXI_awready = wr_take && !wr_grant;
   assign S0_AXI_wready  = wr_take && !wr_grant;
   assign S1_AXI_awready = wr_take &&  wr_grant;
   assign S1_AXI_wready  = wr_take &&  wr_grant;

   // Address and data channels retire independently; pend flags track each.
   assign aw_next        = aw_pend && !M_AXI_awready;
   assign w_next         = w_pend  && !M_AXI_wready;

   assign M_AXI_awvalid  = aw_pend;
   assign M_AXI_awaddr   = wr_addr;
   assign M_AXI_awprot   = wr_prot;
   assign M_AXI_wvalid   = w_pend;
   assign M_AXI_wdata    = wr_data;
   assign M_AXI_wstrb    = wr_strb;
   assign M_AXI_bready   = wr_resp_ph && (wr_owner ? S1_AXI_bready : S0_AXI_bready);

   assign S0_AXI_bvalid  = wr_resp_ph && !wr_owner && M_AXI_bvalid;
   assign S1_AXI_bvalid  = wr_resp_ph &&  wr_owner && M_AXI_bvalid;
   assign S0_AXI_bresp   = M_AXI_bresp;
   assign S1_AXI_bresp   = M_AXI_bresp;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_state <= W_IDLE;
         wr_ptr   <= PRI0;
         wr_owner <= PRI0;
         wr_addr  <= '0;
         wr_prot  <= '0;
         wr_data  <= '0;
         wr_strb  <= '0;
         aw_pend  <= 1'b0;
         w_pend   <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: if (wr_take) begin
               wr_owner <= wr_grant;
               wr_addr  <= wr_grant ? S1_AXI_awaddr : S0_AXI_awaddr;
               wr_prot  <= wr_grant ? S1_AXI_awprot : S0_AXI_awprot;
               wr_data  <= wr_grant ? S1_AXI_wdata  : S0_AXI_wdata;
               wr_strb  <= wr_grant ? S1_AXI_wstrb  : S0_AXI_wstrb;
               aw_pend  <= 1'b1;
               w_pend   <= 1'b1;
               wr_state <= W_ISSUE;
            end
            W_ISSUE: begin
               aw_pend <= aw_next;
               w_pend  <= w_next;
               if (!aw_next && !w_next) wr_state <= W_RESP;
            end
            W_RESP: if (M_AXI_bvalid && M_AXI_bready) begin
               wr_ptr   <= !wr_owner;
               wr_state <= W_IDLE;
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
